// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: the 4-bit state encoding,
// default loop/watchdog settings and a small state classification helper.
package cnn_seq_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_TO_CYC = 50000;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_ST_CNN      = 4'd1,
        S_IBUF_RD     = 4'd2,
        S_CONVOL      = 4'd3,
        S_LST_OBUF_WR = 4'd4,
        S_ST_LCDIF    = 4'd5,
        S_LCDIF       = 4'd6,
        S_CNN_DONE    = 4'd7,
        S_NEXT_CH     = 4'd8,
        S_ERROR       = 4'd9
    } state_t;

    // States that wait on an engine's done input and are therefore watched.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_IBUF_RD) || (s == S_CONVOL) || (s == S_LCDIF);
    endfunction

endpackage

// File: rtl/cnn_seq_wdog.sv
// Per-phase watchdog counter for the CNN layer sequencer. Only instantiated
// when CNN_LAYER_SEQ_TIMEOUT_EN is defined. The count restarts on "clear"
// and advances on "count"; wExpire flags the last permitted cycle.
module cnn_seq_wdog #(
    parameter int TO_W   = 16,
    parameter int TO_CYC = 50000
) (
    input  logic iClk,
    input  logic wRsn,
    input  logic wEnClk,
    input  logic clear,
    input  logic count,
    output logic wExpire
);

    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] cnt;

    // Counter: cleared on entry to a watched phase, advances each enabled cycle in it.
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            cnt <= '0;
        end else if (wEnClk) begin
            if (clear) begin
                cnt <= '0;
            end else if (count) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign wExpire = (cnt == LAST_CNT);

endmodule

// File: rtl/cnn_layer_seq.sv
// Top-level CNN layer sequencer: loops IBuf read -> convolution -> output
// buffer write over NUM_CH channels, then runs the LCD transfer.
// Optional per-phase watchdog under CNN_LAYER_SEQ_TIMEOUT_EN; without it the
// ERROR state is unreachable and wErr is tied low.
//
// Start/done handshake: each start strobe is a level that stays high for as
// long as its state is held (one cycle with wEnClk tied high). Done inputs are
// sampled only on enabled edges and only in the state waiting for them; a done
// arriving in any other state is ignored.
module cnn_layer_seq
    import cnn_seq_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = 2,
    parameter int TO_W   = 16,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic            iClk,
    input  logic            wRsn,
    input  logic            wEnClk,
    input  logic            wEnStart,
    input  logic            wAbort,
    input  logic            wIBufRdDone,
    input  logic            wConvolDone,
    input  logic            wLcdIfDone,
    output logic            wStCnn,
    output logic            wStCh,
    output logic            wStLcdIf,
    output logic            wBusy,
    output logic            wDone,
    output logic            wErr,
    output logic [CH_W-1:0] rChIdx,
    output logic [3:0]      rM_CurState
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Elaboration-time guard on the watchdog range; an illegal setting leaves
    // a named marker block in the hierarchy.
    if ((TO_CYC < 2) || (TO_W < 2)) begin : g_bad_to_cfg
    end

    state_t          state;
    state_t          next_state;
    logic [CH_W-1:0] ch_idx;
    logic [CH_W-1:0] next_ch;
    logic            wait_done;
    logic            timeout;

    // Done input that the current state is waiting on (0 elsewhere).
    always_comb begin
        wait_done = 1'b0;
        case (state)
            S_IBUF_RD: wait_done = wIBufRdDone;
            S_CONVOL:  wait_done = wConvolDone;
            S_LCDIF:   wait_done = wLcdIfDone;
            default:   wait_done = 1'b0;
        endcase
    end

`ifdef CNN_LAYER_SEQ_TIMEOUT_EN
    logic wdog_clear;
    logic wdog_count;
    logic wdog_expire;

    assign wdog_clear = (next_state != state) && is_wait_state(next_state);
    assign wdog_count = is_wait_state(state);

    cnn_seq_wdog #(
        .TO_W   (TO_W),
        .TO_CYC (TO_CYC)
    ) u_wdog (
        .iClk    (iClk),
        .wRsn    (wRsn),
        .wEnClk  (wEnClk),
        .clear   (wdog_clear),
        .count   (wdog_count),
        .wExpire (wdog_expire)
    );

    // Done wins over an expiry landing on the same cycle.
    assign timeout = wdog_expire && !wait_done;
`else
    assign timeout = 1'b0;
`endif

    // State and channel registers; all updates are gated through next_state/next_ch.
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            state  <= S_IDLE;
            ch_idx <= '0;
        end else begin
            state  <= next_state;
            ch_idx <= next_ch;
        end
    end

    // Next-state and channel logic; abort outranks everything outside IDLE.
    always_comb begin
        next_state = state;
        next_ch    = ch_idx;
        if (wEnClk) begin
            if (wAbort && (state != S_IDLE)) begin
                next_state = S_IDLE;
                next_ch    = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wEnStart) begin
                            next_state = S_ST_CNN;
                            next_ch    = '0;
                        end
                    end
                    S_ST_CNN: begin
                        next_state = S_IBUF_RD;
                    end
                    S_IBUF_RD: begin
                        if (wait_done) begin
                            next_state = S_CONVOL;
                        end else if (timeout) begin
                            next_state = S_ERROR;
                        end
                    end
                    S_CONVOL: begin
                        if (wait_done) begin
                            next_state = S_LST_OBUF_WR;
                        end else if (timeout) begin
                            next_state = S_ERROR;
                        end
                    end
                    S_LST_OBUF_WR: begin
                        // ch_idx never passes LAST_CH, so inequality means "more channels".
                        if (ch_idx != LAST_CH) begin
                            next_state = S_NEXT_CH;
                        end else begin
                            next_state = S_ST_LCDIF;
                        end
                    end
                    S_NEXT_CH: begin
                        next_state = S_IBUF_RD;
                        next_ch    = ch_idx + 1'b1;
                    end
                    S_ST_LCDIF: begin
                        next_state = S_LCDIF;
                    end
                    S_LCDIF: begin
                        if (wait_done) begin
                            next_state = S_CNN_DONE;
                        end else if (timeout) begin
                            next_state = S_ERROR;
                        end
                    end
                    S_CNN_DONE: begin
                        next_state = S_IDLE;
                        next_ch    = '0;
                    end
                    S_ERROR: begin
                        next_state = S_ERROR;
                    end
                    default: begin
                        next_state = S_IDLE;
                        next_ch    = '0;
                    end
                endcase
            end
        end
    end

    // Output decode, purely from the current state.
    always_comb begin
        wStCnn   = (state == S_ST_CNN);
        wStCh    = (state == S_ST_CNN) || (state == S_NEXT_CH);
        wStLcdIf = (state == S_ST_LCDIF);
        wBusy    = (state != S_IDLE);
        wDone    = (state == S_CNN_DONE);
`ifdef CNN_LAYER_SEQ_TIMEOUT_EN
        wErr     = (state == S_ERROR);
`else
        wErr     = 1'b0;
`endif
    end

    assign rChIdx      = ch_idx;
    assign rM_CurState = state;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Scoreboard bench for cnn_layer_seq: a 3-channel instance (a) and a
// 1-channel instance (b) share stimulus; every state change is checked
// against hand-derived {state, channel, strobes, cycle-offset} entries.
// Watchdog cases run only when CNN_LAYER_SEQ_TIMEOUT_EN is defined.
module tb_cnn_layer_seq;

    localparam int W = 32;

    logic iClk = 1'b0;
    logic wRsn, wEnClk, wEnStart, wAbort;
    logic wIBufRdDone, wConvolDone, wLcdIfDone;

    logic st_cnn_a, st_ch_a, st_lcd_a, busy_a, done_a, err_a;
    logic [1:0] ch_a;
    logic [3:0] state_a;
    logic st_cnn_b, st_ch_b, st_lcd_b, busy_b, done_b, err_b;
    logic [1:0] ch_b;
    logic [3:0] state_b;

    cnn_layer_seq #(.NUM_CH(3), .CH_W(2), .TO_W(16), .TO_CYC(8)) dut_a (
        .iClk(iClk), .wRsn(wRsn), .wEnClk(wEnClk), .wEnStart(wEnStart), .wAbort(wAbort),
        .wIBufRdDone(wIBufRdDone), .wConvolDone(wConvolDone), .wLcdIfDone(wLcdIfDone),
        .wStCnn(st_cnn_a), .wStCh(st_ch_a), .wStLcdIf(st_lcd_a), .wBusy(busy_a),
        .wDone(done_a), .wErr(err_a), .rChIdx(ch_a), .rM_CurState(state_a)
    );

    cnn_layer_seq #(.NUM_CH(1), .CH_W(2), .TO_W(16), .TO_CYC(50000)) dut_b (
        .iClk(iClk), .wRsn(wRsn), .wEnClk(wEnClk), .wEnStart(wEnStart), .wAbort(wAbort),
        .wIBufRdDone(wIBufRdDone), .wConvolDone(wConvolDone), .wLcdIfDone(wLcdIfDone),
        .wStCnn(st_cnn_b), .wStCh(st_ch_b), .wStLcdIf(st_lcd_b), .wBusy(busy_b),
        .wDone(done_b), .wErr(err_b), .rChIdx(ch_b), .rM_CurState(state_b)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 iClk = ~iClk;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];
    int chk = 0;
    int err = 0;
    bit mon_a_en = 1'b0;
    bit mon_b_en = 1'b0;
    bit en_mode = 1'b0;
    logic [3:0] prev_a = 4'd0;
    logic [3:0] prev_b = 4'd0;

    logic [15:0] rel;
    logic [5:0] flags_a, flags_b;
    logic [W-1:0] act_a, act_b;
    assign rel     = 16'(cyc - start_cyc);
    assign flags_a = {st_cnn_a, st_ch_a, st_lcd_a, busy_a, done_a, err_a};
    assign flags_b = {st_cnn_b, st_ch_b, st_lcd_b, busy_b, done_b, err_b};
    assign act_a   = {state_a, ch_a, flags_a, 4'h0, rel};
    assign act_b   = {state_b, ch_b, flags_b, 4'h0, rel};

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [W-1:0] act);
        chk++;
        err++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    // Strobe vector {stcnn, stch, stlcd, busy, done, err} each state must show.
    function automatic logic [5:0] exp_flags(input logic [3:0] s);
        case (s)
            4'd0:    return 6'b000000;
            4'd1:    return 6'b110100;
            4'd5:    return 6'b001100;
            4'd7:    return 6'b000110;
            4'd8:    return 6'b010100;
            4'd9:    return 6'b000101;
            default: return 6'b000100;
        endcase
    endfunction

    function automatic logic [W-1:0] mk(input logic [3:0] s, input logic [1:0] c, input int r);
        logic [15:0] r16;
        r16 = 16'(r);
        return {s, c, exp_flags(s), 4'h0, r16};
    endfunction

    task automatic push(input bit to_a, input logic [3:0] s, input logic [1:0] c, input int r);
        if (to_a) exp_qa.push_back(mk(s, c, r));
        else      exp_qb.push_back(mk(s, c, r));
    endtask

    // Expected frame: state entries spaced by "step" cycles; "stall" extra
    // cycles are spent in CONVOL of channel 0.
    task automatic push_flow(input bit to_a, input int nch, input int step, input int stall);
        int r;
        r = 1;
        push(to_a, 4'd1, 2'd0, r); r += step;
        for (int c = 0; c < nch; c++) begin
            push(to_a, 4'd2, 2'(c), r); r += step;
            push(to_a, 4'd3, 2'(c), r); r += step;
            if (c == 0) r += stall;
            push(to_a, 4'd4, 2'(c), r); r += step;
            if (c < nch - 1) begin
                push(to_a, 4'd8, 2'(c), r); r += step;
            end
        end
        push(to_a, 4'd5, 2'(nch - 1), r); r += step;
        push(to_a, 4'd6, 2'(nch - 1), r); r += step;
        push(to_a, 4'd7, 2'(nch - 1), r); r += step;
        push(to_a, 4'd0, 2'd0, r);
    endtask

    // Monitor: every state change of either DUT is popped and compared.
    always @(negedge iClk) begin
        if (mon_a_en && (state_a != prev_a)) begin
            if (exp_qa.size() == 0) note_fail("evt_a_unexpected", act_a);
            else check("evt_a", act_a, exp_qa.pop_front());
        end
        if (mon_b_en && (state_b != prev_b)) begin
            if (exp_qb.size() == 0) note_fail("evt_b_unexpected", act_b);
            else check("evt_b", act_b, exp_qb.pop_front());
        end
        prev_a <= state_a;
        prev_b <= state_b;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle();
        @(negedge iClk);
        wEnClk = en_mode ? (cyc % 4 == 3) : 1'b1;
    endtask

    task automatic pulse_start(input logic with_abort);
        int n;
        n = 0;
        drive_cycle();
        while (!wEnClk && n < 8) begin
            drive_cycle();
            n++;
        end
        wEnStart  = 1'b1;
        wAbort    = with_abort;
        start_cyc = cyc;
        drive_cycle();
        wEnStart = 1'b0;
        wAbort   = 1'b0;
    endtask

    task automatic run_to_rel(input int r);
        int n;
        n = 0;
        while ((cyc - start_cyc) < r && n < 200) begin
            drive_cycle();
            n++;
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_qa.size() > 0 || (mon_b_en && exp_qb.size() > 0)) && n < max_cyc) begin
            drive_cycle();
            n++;
        end
        check("drain_a_left", W'(exp_qa.size()), '0);
        if (mon_b_en) check("drain_b_left", W'(exp_qb.size()), '0);
        exp_qa.delete();
        exp_qb.delete();
        repeat (2) drive_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wRsn = 1'b0; wEnClk = 1'b1; wEnStart = 1'b0; wAbort = 1'b0;
        wIBufRdDone = 1'b1; wConvolDone = 1'b1; wLcdIfDone = 1'b1;
        repeat (3) drive_cycle();

        // Reset state
        check("rst_state_a", W'(state_a), W'(0));
        check("rst_ch_a", W'(ch_a), W'(0));
        check("rst_flags_a", W'(flags_a), W'(0));
        check("rst_state_b", W'(state_b), W'(0));
        check("rst_flags_b", W'(flags_b), W'(0));
        wRsn = 1'b1;
        drive_cycle();
        mon_a_en = 1'b1;
        mon_b_en = 1'b1;

        // Full frames: 3 channels (done at +15) and 1 channel (done at +7)
        push_flow(1'b1, 3, 1, 0);
        push_flow(1'b0, 1, 1, 0);
        pulse_start(1'b0);
        wait_drain(100);

        // Clock enable every 4th cycle: each state lasts 4 cycles
        en_mode = 1'b1;
        push_flow(1'b1, 3, 4, 0);
        push_flow(1'b0, 1, 4, 0);
        pulse_start(1'b0);
        wait_drain(200);
        en_mode = 1'b0;

        // Start together with abort in IDLE starts; abort in CONVOL of channel 1
        push(1'b1, 4'd1, 2'd0, 1); push(1'b1, 4'd2, 2'd0, 2);
        push(1'b1, 4'd3, 2'd0, 3); push(1'b1, 4'd4, 2'd0, 4);
        push(1'b1, 4'd8, 2'd0, 5); push(1'b1, 4'd2, 2'd1, 6);
        push(1'b1, 4'd3, 2'd1, 7); push(1'b1, 4'd0, 2'd0, 8);
        push_flow(1'b0, 1, 1, 0);
        pulse_start(1'b1);
        run_to_rel(7);
        wAbort = 1'b1;
        drive_cycle();
        wAbort = 1'b0;
        wait_drain(50);
        check("abort_ch_a", W'(ch_a), W'(0));

`ifdef CNN_LAYER_SEQ_TIMEOUT_EN
        mon_b_en = 1'b0;
        // Watchdog expiry in CONVOL after 8 enabled cycles
        wConvolDone = 1'b0;
        push(1'b1, 4'd1, 2'd0, 1); push(1'b1, 4'd2, 2'd0, 2);
        push(1'b1, 4'd3, 2'd0, 3); push(1'b1, 4'd9, 2'd0, 11);
        pulse_start(1'b0);
        run_to_rel(14);
        check("to_state_a", W'(state_a), W'(9));
        check("to_err_a", W'(err_a), W'(1));
        wEnStart = 1'b1;
        drive_cycle();
        wEnStart = 1'b0;
        repeat (2) drive_cycle();
        check("err_hold_a", W'(state_a), W'(9));
        wAbort    = 1'b1;
        start_cyc = cyc;
        push(1'b1, 4'd0, 2'd0, 1);
        drive_cycle();
        wAbort = 1'b0;
        wait_drain(20);
        check("err_clear_a", W'(err_a), W'(0));

        // Done arriving on the last permitted CONVOL cycle wins
        push_flow(1'b1, 3, 1, 7);
        pulse_start(1'b0);
        run_to_rel(10);
        wConvolDone = 1'b1;
        wait_drain(50);
`endif

        // Asynchronous reset in the middle of LCDIF
        mon_a_en = 1'b0;
        mon_b_en = 1'b0;
        wLcdIfDone = 1'b0;
        pulse_start(1'b0);
        begin
            int n;
            n = 0;
            while (state_a != 4'd6 && n < 40) begin
                drive_cycle();
                n++;
            end
        end
        check("lcdif_reached_a", W'(state_a), W'(6));
        drive_cycle();
        wRsn = 1'b0;
        #1;
        check("async_rst_state_a", W'(state_a), W'(0));
        check("async_rst_ch_a", W'(ch_a), W'(0));
        check("async_rst_busy_a", W'(busy_a), W'(0));
        check("async_rst_state_b", W'(state_b), W'(0));
        drive_cycle();
        wRsn = 1'b1;
        wLcdIfDone = 1'b1;
        repeat (2) drive_cycle();
        check("post_rst_state_a", W'(state_a), W'(0));

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
